seq_detect_ctrl: RTL and testbench

- Programmable serial-pattern detection controller for the sequence-detection datapath.
- Configures the target pattern and its length, arms and disarms detection, and samples the serial input `A` only when `a_valid` is high.
- Counts matches and raises `done` once a programmed match target is reached.
- Software- or FSM-facing front end; it replaces hard-wired detectors with one reusable sequenced block.

---
 rtl/seq_detect_ctrl_if.sv | 31 +++
 rtl/seq_detect_ctrl.sv | 119 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// Handshake/configuration bundle between a controller and the seq_detect_ctrl block.
// Parameters must match the PAT_W/CNT_W of the attached seq_detect_ctrl instance.
interface seq_detect_ctrl_if #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
);
   localparam int LEN_W = $clog2(PAT_W + 1);

   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic [CNT_W-1:0] cfg_target;
   logic             start;
   logic             stop;
   logic             A;
   logic             a_valid;
   logic             Z;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_count;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_target, start, stop, A, a_valid,
      input  Z, busy, done, match_count
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_target, start, stop, A, a_valid,
      output Z, busy, done, match_count
   );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector with match counting and a DONE target.
// Optional macro SEQ_DETECT_NONOVERLAP_EN makes matches non-overlapping.
module seq_detect_ctrl #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              reset,
   seq_detect_ctrl_if.slave bus
);
   localparam int LEN_W = $clog2(PAT_W + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   state_t           state_q;
   logic [PAT_W-1:0] pattern_q;
   logic [PAT_W-1:0] hist_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] fill_q;
   logic [CNT_W-1:0] target_q;
   logic [CNT_W-1:0] count_q;
   logic             z_q;

   logic [PAT_W-1:0] hist_d;
   logic [PAT_W-1:0] lenMask;
   logic [LEN_W-1:0] fill_d;
   logic [LEN_W-1:0] cfgLen_d;
   logic [CNT_W-1:0] count_d;
   logic             matchHit;

   // Candidate next values for a consuming cycle; the match is judged on the post-shift history.
   always_comb begin
      hist_d  = {hist_q[PAT_W-2:0], bus.A};
      fill_d  = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
      count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
      lenMask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         lenMask[i] = (i < int'(len_q));
      end
      matchHit = (((hist_d ^ pattern_q) & lenMask) == '0) && (fill_d >= len_q);
      if (bus.cfg_len == '0) begin
         cfgLen_d = LEN_W'(1);
      end else if (bus.cfg_len > LEN_MAX) begin
         cfgLen_d = LEN_MAX;
      end else begin
         cfgLen_d = bus.cfg_len;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         hist_q    <= '0;
         len_q     <= LEN_W'(1);
         fill_q    <= '0;
         target_q  <= '0;
         count_q   <= '0;
         z_q       <= 1'b0;
      end else begin
         z_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.cfg_we) begin
                  pattern_q <= bus.cfg_pattern;
                  len_q     <= cfgLen_d;
                  target_q  <= bus.cfg_target;
               end
               if (bus.start && !bus.stop) begin
                  state_q <= ARMED;
                  hist_q  <= '0;
                  fill_q  <= '0;
                  count_q <= '0;
               end
            end
            ARMED: begin
               // stop takes priority over consuming a bit offered in the same cycle
               if (bus.stop) begin
                  state_q <= IDLE;
               end else if (bus.a_valid) begin
                  hist_q <= hist_d;
                  if (matchHit) begin
                     z_q     <= 1'b1;
                     count_q <= count_d;
`ifdef SEQ_DETECT_NONOVERLAP_EN
                     fill_q  <= '0;
`else
                     fill_q  <= fill_d;
`endif
                     if ((target_q != '0) && (count_d == target_q)) begin
                        state_q <= DONE;
                     end
                  end else begin
                     fill_q <= fill_d;
                  end
               end
            end
            DONE: begin
               if (bus.stop) begin
                  state_q <= IDLE;
               end else if (bus.start) begin
                  state_q <= ARMED;
                  hist_q  <= '0;
                  fill_q  <= '0;
                  count_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Z           = z_q;
   assign bus.busy        = (state_q == ARMED);
   assign bus.done        = (state_q == DONE);
   assign bus.match_count = count_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl: a default-width instance
// plus a CNT_W=2 instance for counter saturation.
module tb_seq_detect_ctrl;
   logic clk;
   logic reset;
   int   compareCount = 0;
   int   failCount    = 0;

   seq_detect_ctrl_if #(.PAT_W(8), .CNT_W(8)) bus ();
   seq_detect_ctrl_if #(.PAT_W(8), .CNT_W(2)) bus2 ();

   seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   seq_detect_ctrl #(.PAT_W(8), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one bit for one cycle; returns #1 after the consuming edge.
   task automatic applyStimulus(input logic a, input logic v);
      bus.A       = a;
      bus.a_valid = v;
      tick();
      bus.a_valid = 1'b0;
   endtask

   task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
      bus.cfg_we      = 1'b1;
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_target  = tgt;
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic pulseCtrl(input logic s, input logic p);
      bus.start = s;
      bus.stop  = p;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
   endtask

   initial begin
      logic [6:0] stream7;
      logic [6:0] expZ7;
      logic [7:0] stream8;
      stream7 = 7'b1011011;
`ifdef SEQ_DETECT_NONOVERLAP_EN
      expZ7 = 7'b0001000;
`else
      expZ7 = 7'b0001001;
`endif
      stream8 = 8'b10111011;

      reset = 1'b0;
      bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_target = 0;
      bus.start = 0; bus.stop = 0; bus.A = 0; bus.a_valid = 0;
      bus2.cfg_we = 0; bus2.cfg_pattern = 0; bus2.cfg_len = 0; bus2.cfg_target = 0;
      bus2.start = 0; bus2.stop = 0; bus2.A = 0; bus2.a_valid = 0;
      repeat (2) tick();
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_z", bus.Z, 0);
      checkOutput("rst_count", bus.match_count, 0);
      reset = 1'b1;
      tick();

      // Reset defaults: pattern 0, len 1, so a valid 0 matches; then reset mid-ARMED.
      pulseCtrl(1, 0);
      checkOutput("arm_busy", bus.busy, 1);
      applyStimulus(0, 1);
      checkOutput("dflt_z", bus.Z, 1);
      checkOutput("dflt_count", bus.match_count, 1);
      reset = 1'b0;
      #2;
      checkOutput("midrst_busy", bus.busy, 0);
      checkOutput("midrst_z", bus.Z, 0);
      checkOutput("midrst_count", bus.match_count, 0);
      reset = 1'b1;

      configure(8'b0000_1011, 4'd4, 8'd0);
      pulseCtrl(1, 0);
      checkOutput("cfg_busy", bus.busy, 1);

      for (int i = 6; i >= 0; i--) begin
         applyStimulus(stream7[i], 1);
         checkOutput($sformatf("ovl_z%0d", 7 - i), bus.Z, expZ7[i]);
      end
      applyStimulus(0, 0);
      checkOutput("ovl_zdrop", bus.Z, 0);
      checkOutput("ovl_count", bus.match_count, expZ7[0] ? 2 : 1);
      checkOutput("ovl_done", bus.done, 0);

      pulseCtrl(0, 1);
      checkOutput("stop_busy", bus.busy, 0);
      checkOutput("stop_count_held", bus.match_count, expZ7[0] ? 2 : 1);
      pulseCtrl(1, 0);
      checkOutput("rearm_count", bus.match_count, 0);

      // Same stream with three invalid cycles after each bit; A=1 during gaps must be ignored.
      for (int i = 6; i >= 0; i--) begin
         applyStimulus(stream7[i], 1);
         checkOutput($sformatf("gap_z%0d", 7 - i), bus.Z, expZ7[i]);
         for (int g = 0; g < 3; g++) begin
            applyStimulus(1, 0);
            checkOutput("gap_idle_z", bus.Z, 0);
         end
      end
      checkOutput("gap_count", bus.match_count, expZ7[0] ? 2 : 1);

      pulseCtrl(0, 1);
      configure(8'b0000_1011, 4'd4, 8'd2);
      pulseCtrl(1, 0);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(stream8[i], 1);
         checkOutput($sformatf("tgt_z%0d", 8 - i), bus.Z, (i == 4 || i == 0) ? 1 : 0);
      end
      checkOutput("tgt_done", bus.done, 1);
      checkOutput("tgt_busy", bus.busy, 0);
      checkOutput("tgt_count", bus.match_count, 2);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(stream8[i], 1);
         checkOutput("done_noz", bus.Z, 0);
      end
      checkOutput("done_count_held", bus.match_count, 2);
      pulseCtrl(1, 0);
      checkOutput("done_rearm_busy", bus.busy, 1);
      checkOutput("done_rearm_done", bus.done, 0);
      checkOutput("done_rearm_count", bus.match_count, 0);

      // Config write while ARMED is dropped: old pattern and target=2 remain in force.
      configure(8'b0000_0000, 4'd2, 8'd1);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(stream8[i], 1);
         checkOutput($sformatf("cfgign_z%0d", 4 - i), bus.Z, (i == 0) ? 1 : 0);
      end
      checkOutput("cfgign_busy", bus.busy, 1);
      checkOutput("cfgign_count", bus.match_count, 1);

      pulseCtrl(1, 1);
      checkOutput("startstop_armed", bus.busy, 0);
      pulseCtrl(1, 1);
      checkOutput("startstop_idle", bus.busy, 0);

      configure(8'b0000_0001, 4'd0, 8'd0);
      pulseCtrl(1, 0);
      applyStimulus(1, 1);
      checkOutput("len0_z1", bus.Z, 1);
      applyStimulus(0, 1);
      checkOutput("len0_z0", bus.Z, 0);
      applyStimulus(1, 1);
      checkOutput("len0_z1b", bus.Z, 1);
      checkOutput("len0_count", bus.match_count, 2);

      // cfg_len=15 clamps to 8: eight valid ones needed before the first match.
      pulseCtrl(0, 1);
      configure(8'hFF, 4'd15, 8'd0);
      pulseCtrl(1, 0);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1, 1);
         checkOutput($sformatf("clamp_z%0d", i), bus.Z, (i == 8) ? 1 : 0);
      end

      // Narrow counter saturates at 3 while Z keeps pulsing.
      bus2.cfg_we = 1; bus2.cfg_pattern = 8'h01; bus2.cfg_len = 4'd1; bus2.cfg_target = 2'd0;
      tick();
      bus2.cfg_we = 0;
      bus2.start = 1;
      tick();
      bus2.start = 0;
      for (int i = 1; i <= 5; i++) begin
         bus2.A = 1; bus2.a_valid = 1;
         tick();
         bus2.a_valid = 0;
         checkOutput($sformatf("sat_z%0d", i), bus2.Z, 1);
         checkOutput($sformatf("sat_count%0d", i), bus2.match_count, (i < 3) ? i : 3);
      end
      checkOutput("sat_busy", bus2.busy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end
endmodule
